disp_arbiter: RTL and testbench

Time-shares the board's single 4-digit seven-segment display between several on-chip requesters, such as the DAC waveform status and the moving-block position/score. It sits directly in front of the seven-segment scan/decode block. Its registered nibble outputs drive that block's four digit inputs. It runs a round-robin grant with a guaranteed minimum dwell per owner, so every value stays on screen long enough to read.

---
 rtl/disp_arbiter.sv | 168 ++++++++++++++++
 tb/tb_disp_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/disp_arbiter.sv
// disp_arbiter
//   Time-shares the single 4-digit seven-segment display between NUM_REQ
//   on-chip requesters. Round-robin grant with a guaranteed minimum dwell
//   per owner; the registered digit nibbles feed the scan/decode block.
//
// Parameters
//   NUM_REQ       number of requesters (2..8)
//   DWELL_CYCLES  minimum cycles an owner holds the display (>= 2)
//
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   req      per-requester level request
//   data     requester i's word at bits [16i+15:16i]
//   grant    one-hot current owner, zero when idle
//   ack      one-cycle pulse when the owner's word is first latched
//   digit_a  word bits [3:0]   (rightmost digit)
//   digit_b  word bits [7:4]
//   digit_c  word bits [11:8]
//   digit_d  word bits [15:12] (leftmost digit)
//   busy     high while in LOAD or DWELL
//
// Configuration
//   DISP_ARB_PRIO_EN  when defined, requester 0 is urgent and preempts any
//                     other owner's dwell; otherwise pure round-robin.

module disp_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int DWELL_CYCLES = 100_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [16*NUM_REQ-1:0]  data,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     ack,
  output logic [3:0]             digit_a,
  output logic [3:0]             digit_b,
  output logic [3:0]             digit_c,
  output logic [3:0]             digit_d,
  output logic                   busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DWELL} state_t;

  state_t            state;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  last;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       disp_word;

  logic [15:0]       words [NUM_REQ];
  logic [15:0]       cur_word;
  logic [NUM_REQ-1:0] arb_mask;
  logic              arb_found;
  logic [IDX_W-1:0]  arb_winner;
  logic              preempt;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = data[16*g +: 16];
  end

  assign cur_word = words[owner];

  // In DWELL the current owner is masked out so only "other" requesters
  // can win at the end of a dwell; in IDLE everyone competes.
  assign arb_mask = (state == IDLE) ? req : (req & ~grant);

  // Round-robin search starting just after the last owner.
  always_comb begin
    int idx;
    idx        = 0;
    arb_found  = 1'b0;
    arb_winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!arb_found && arb_mask[idx[IDX_W-1:0]]) begin
        arb_found  = 1'b1;
        arb_winner = idx[IDX_W-1:0];
      end
    end
  end

`ifdef DISP_ARB_PRIO_EN
  // Requester 0 aborts anyone else's dwell but never its own.
  assign preempt = (state == DWELL) && req[0] && (owner != '0);
`else
  assign preempt = 1'b0;
`endif

  assign digit_a = disp_word[3:0];
  assign digit_b = disp_word[7:4];
  assign digit_c = disp_word[11:8];
  assign digit_d = disp_word[15:12];

  // Single FSM with registered outputs. Digits are never cleared outside
  // reset so the display keeps showing the last word while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      last      <= IDX_LAST;
      cnt       <= '0;
      grant     <= '0;
      ack       <= '0;
      busy      <= 1'b0;
      disp_word <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (arb_found) begin
            owner <= arb_winner;
            grant <= onehot(arb_winner);
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          disp_word <= cur_word;
          ack       <= onehot(owner);
          cnt       <= '0;
          last      <= owner;
          state     <= DWELL;
        end
        DWELL: begin
          if (req[owner]) begin
            disp_word <= cur_word;
          end
          if (preempt) begin
            owner <= '0;
            grant <= onehot('0);
            state <= LOAD;
          end else if (cnt == CNT_LAST) begin
            // A dropped owner request at this same edge is not retained.
            if (arb_found) begin
              owner <= arb_winner;
              grant <= onehot(arb_winner);
              state <= LOAD;
            end else if (req[owner]) begin
              cnt <= '0;
            end else begin
              grant <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter
//   Directed bench for disp_arbiter with NUM_REQ=3, DWELL_CYCLES=8.
//   Expected values are hand-derived from the arbiter's behaviour.
//   Honours DISP_ARB_PRIO_EN for the preemption scenario.

module tb_disp_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DWELL   = 8;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [47:0] data;
  logic [2:0]  grant;
  logic [2:0]  ack;
  logic [3:0]  digit_a, digit_b, digit_c, digit_d;
  logic        busy;
  logic [15:0] digits;

  int checks   = 0;
  int failures = 0;

  disp_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .data    (data),
    .grant   (grant),
    .ack     (ack),
    .digit_a (digit_a),
    .digit_b (digit_b),
    .digit_c (digit_c),
    .digit_d (digit_d),
    .busy    (busy)
  );

  assign digits = {digit_d, digit_c, digit_b, digit_a};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h required=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic [15:0] d0,
                               input logic [15:0] d1, input logic [15:0] d2);
    req  = r;
    data = {d2, d1, d0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    applyStimulus(3'b000, 16'h0, 16'h0, 16'h0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic waitIdle(input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    checkOutput("wait_idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int idx;
    logic [2:0] exp_g;
    logic [2:0] exp_a;

    // Reset held low with random activity on the inputs.
    rst_n = 1'b0;
    applyStimulus(3'b000, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)),
                    16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      tick();
      checkOutput("reset_hold", {9'b0, grant, ack, busy, digits}, 32'd0);
    end
    rst_n = 1'b1;
    applyStimulus(3'b000, 16'h0, 16'h0, 16'h0);
    tick();
    checkOutput("idle_busy", {31'b0, busy}, 32'd0);

    // Single requester 0: grant, ack, digits, then re-dwell without ack.
    applyStimulus(3'b001, 16'h1234, 16'h0, 16'h0);
    tick();
    checkOutput("s2_grant", {29'b0, grant}, 32'h1);
    checkOutput("s2_busy", {31'b0, busy}, 32'h1);
    checkOutput("s2_ack_early", {29'b0, ack}, 32'h0);
    tick();
    checkOutput("s2_ack", {29'b0, ack}, 32'h1);
    checkOutput("s2_digits", {16'b0, digits}, 32'h1234);
    for (int e = 3; e <= 12; e++) begin
      tick();
      checkOutput("s2_hold_grant", {29'b0, grant}, 32'h1);
      checkOutput("s2_no_ack", {29'b0, ack}, 32'h0);
    end
    applyStimulus(3'b000, 16'h1234, 16'h0, 16'h0);
    waitIdle(20);

    // All requesters: round-robin 001,010,100,001 with 9-cycle tenure.
    applyReset();
    applyStimulus(3'b111, 16'h1111, 16'h2222, 16'h3333);
    for (int e = 1; e <= 36; e++) begin
      tick();
      idx   = ((e - 1) / 9) % 3;
      exp_g = 3'b001 << idx;
      exp_a = ((e - 1) % 9 == 1) ? exp_g : 3'b000;
      checkOutput("rr_grant", {29'b0, grant}, {29'b0, exp_g});
      checkOutput("rr_ack", {29'b0, ack}, {29'b0, exp_a});
      if ((e - 1) % 9 == 1)
        checkOutput("rr_digits", {16'b0, digits}, 32'(16'h1111 * (idx + 1)));
    end
    applyStimulus(3'b000, 16'h0, 16'h0, 16'h0);
    waitIdle(20);

    // Live tracking, then owner drop: digits freeze, dwell completes.
    applyReset();
    applyStimulus(3'b001, 16'h1234, 16'h0, 16'h0);
    for (int e = 1; e <= 4; e++) tick();
    applyStimulus(3'b001, 16'hABCD, 16'h0, 16'h0);
    tick();
    checkOutput("s4_track", {16'b0, digits}, 32'hABCD);
    tick();
    applyStimulus(3'b000, 16'h5555, 16'h0, 16'h0);
    for (int e = 7; e <= 9; e++) begin
      tick();
      checkOutput("s4_freeze", {16'b0, digits}, 32'hABCD);
      checkOutput("s4_still_busy", {31'b0, busy}, 32'h1);
    end
    tick();
    checkOutput("s4_idle_busy", {31'b0, busy}, 32'h0);
    checkOutput("s4_idle_grant", {29'b0, grant}, 32'h0);
    checkOutput("s4_idle_digits", {16'b0, digits}, 32'hABCD);

    // Asynchronous reset mid-dwell, then requester 1 alone.
    applyStimulus(3'b001, 16'h1234, 16'h0, 16'h0);
    for (int e = 1; e <= 7; e++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("s5_async", {9'b0, grant, ack, busy, digits}, 32'd0);
    tick();
    checkOutput("s5_held", {9'b0, grant, ack, busy, digits}, 32'd0);
    rst_n = 1'b1;
    applyStimulus(3'b010, 16'h0, 16'h4321, 16'h0);
    tick();
    checkOutput("s5_grant", {29'b0, grant}, 32'h2);
    tick();
    checkOutput("s5_ack", {29'b0, ack}, 32'h2);
    checkOutput("s5_digits", {16'b0, digits}, 32'h4321);

    // Requester 0 rises at dwell cycle 3 of requester 1.
    for (int e = 3; e <= 5; e++) tick();
    applyStimulus(3'b011, 16'h0F0F, 16'h4321, 16'h0);
    tick();
`ifdef DISP_ARB_PRIO_EN
    checkOutput("s6_preempt", {29'b0, grant}, 32'h1);
`else
    checkOutput("s6_no_preempt", {29'b0, grant}, 32'h2);
`endif
    for (int e = 7; e <= 9; e++) tick();
`ifdef DISP_ARB_PRIO_EN
    checkOutput("s6_late_grant", {29'b0, grant}, 32'h1);
`else
    checkOutput("s6_late_grant", {29'b0, grant}, 32'h2);
`endif
    tick();
    checkOutput("s6_end_grant", {29'b0, grant}, 32'h1);
    tick();
`ifdef DISP_ARB_PRIO_EN
    checkOutput("s6_ack", {29'b0, ack}, 32'h0);
`else
    checkOutput("s6_ack", {29'b0, ack}, 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
